// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
// Module   : div_seq
// Purpose  : Sequential restoring divider, signed/unsigned, one quotient bit
//            per clock, start/busy/done handshake and sticky divide-by-zero.
// Revision : 1.0 - initial release
// ============================================================================
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        c_idle = 2'b00,
        c_run  = 2'b01,
        c_fix  = 2'b10
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic               r_q_neg;
    logic               r_r_neg;
    logic               r_zero_pend;
    logic               r_busy;
    logic               r_done;
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_b_zero;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_sub;
    logic               w_ge;

    assign w_b_zero = (b == '0);
    // |MIN| is representable as an unsigned magnitude, so plain negation is safe.
    assign w_abs_a  = (is_signed && a[WIDTH-1]) ? (WIDTH'(0) - a) : a;
    assign w_abs_b  = (is_signed && b[WIDTH-1]) ? (WIDTH'(0) - b) : b;

    // Keep the carry-out of the shift so divisors above 2^(W-1) compare correctly.
    assign w_shift  = {r_rem, r_dvd[r_cnt]};
    assign w_sub    = w_shift - {1'b0, r_dvs};
    assign w_ge     = ~w_sub[WIDTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle:  if (start && !w_b_zero) w_next = c_run;
            c_run:   if (r_cnt == '0) w_next = c_fix;
            c_fix:   w_next = c_idle;
            default: w_next = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_zero_pend <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_div_zero  <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else begin
            r_done      <= r_zero_pend;
            r_zero_pend <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (start) begin
                        if (w_b_zero) begin
                            r_div_zero  <= 1'b1;
                            r_hi        <= '0;
                            r_lo        <= '0;
                            r_zero_pend <= 1'b1;
                        end else begin
                            r_dvd      <= w_abs_a;
                            r_dvs      <= w_abs_b;
                            r_q_neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                            r_r_neg    <= is_signed & a[WIDTH-1];
                            r_rem      <= '0;
                            r_quo      <= '0;
                            r_cnt      <= c_cnt_last;
                            r_div_zero <= 1'b0;
                            r_busy     <= 1'b1;
                        end
                    end
                end
                c_run: begin
                    r_rem <= w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt - c_cnt_w'(1);
                end
                c_fix: begin
                    r_lo   <= r_q_neg ? (WIDTH'(0) - r_quo) : r_quo;
                    r_hi   <= r_r_neg ? (WIDTH'(0) - r_rem) : r_rem;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_seq
// Purpose  : Directed self-checking bench for div_seq (W=32 and W=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start32, sgn32, start8, sgn8;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;
    logic        busy32, done32, dz32, busy8, done8, dz8;
    logic [31:0] hi32, lo32;
    logic [7:0]  hi8, lo8;

    div_seq #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset(reset), .start(start32), .is_signed(sgn32),
        .a(a32), .b(b32), .busy(busy32), .done(done32), .div_zero(dz32),
        .hi(hi32), .lo(lo32)
    );

    div_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .is_signed(sgn8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .div_zero(dz8),
        .hi(hi8), .lo(lo8)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic        sel8 = 1'b0;
    logic        m_busy, m_done, m_dz;
    logic [63:0] m_hi, m_lo;

    always_comb begin
        m_busy = sel8 ? busy8 : busy32;
        m_done = sel8 ? done8 : done32;
        m_dz   = sel8 ? dz8   : dz32;
        m_hi   = sel8 ? {56'd0, hi8} : {32'd0, hi32};
        m_lo   = sel8 ? {56'd0, lo8} : {32'd0, lo32};
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit w8, input bit st, input bit sgn, input logic [63:0] av, input logic [63:0] bv);
        if (w8) begin
            start8 = st; sgn8 = sgn; a8 = av[7:0]; b8 = bv[7:0];
        end else begin
            start32 = st; sgn32 = sgn; a32 = av[31:0]; b32 = bv[31:0];
        end
    endtask

    // One division; restart_at > 0 re-asserts start (new operands) at that edge after the start edge.
    task automatic run_div(input string tag, input bit w8, input bit sgn,
                           input logic [63:0] av, input logic [63:0] bv,
                           input logic [63:0] exp_lo, input logic [63:0] exp_hi,
                           input int restart_at);
        int width;
        int lat;
        int busy_bad;
        width    = w8 ? 8 : 32;
        lat      = 0;
        busy_bad = 0;
        sel8     = w8;
        drive(w8, 1'b1, sgn, av, bv);
        @(posedge clk); #1;
        // Operands may change freely after the start edge.
        drive(w8, 1'b0, ~sgn, 64'h5A5A_5A5A_1234_5678, 64'h0000_0000_0000_0003);
        if (bv == 64'd0) begin
            check($sformatf("%s.dz", tag),    {63'd0, m_dz},   64'd1);
            check($sformatf("%s.hi", tag),    m_hi,            64'd0);
            check($sformatf("%s.lo", tag),    m_lo,            64'd0);
            check($sformatf("%s.busy", tag),  {63'd0, m_busy}, 64'd0);
            check($sformatf("%s.done0", tag), {63'd0, m_done}, 64'd0);
            @(posedge clk); #1;
            check($sformatf("%s.done1", tag), {63'd0, m_done}, 64'd1);
            check($sformatf("%s.busy1", tag), {63'd0, m_busy}, 64'd0);
            @(posedge clk); #1;
            check($sformatf("%s.done2", tag), {63'd0, m_done}, 64'd0);
            return;
        end
        check($sformatf("%s.busy_k", tag), {63'd0, m_busy}, 64'd1);
        check($sformatf("%s.dz_k", tag),   {63'd0, m_dz},   64'd0);
        for (int i = 1; i <= 100; i++) begin
            if (i == restart_at) drive(w8, 1'b1, ~sgn, 64'd9, 64'd3);
            @(posedge clk); #1;
            if (i == restart_at) drive(w8, 1'b0, sgn, 64'd0, 64'd0);
            if (m_done) begin
                lat = i;
                break;
            end
            if (!m_busy) busy_bad++;
        end
        check($sformatf("%s.latency", tag),  lat,            width + 1);
        check($sformatf("%s.busy_run", tag), busy_bad,       0);
        check($sformatf("%s.lo", tag),       m_lo,           exp_lo);
        check($sformatf("%s.hi", tag),       m_hi,           exp_hi);
        check($sformatf("%s.dz", tag),       {63'd0, m_dz},   64'd0);
        check($sformatf("%s.busy_end", tag), {63'd0, m_busy}, 64'd0);
        @(posedge clk); #1;
        check($sformatf("%s.done_off", tag), {63'd0, m_done}, 64'd0);
    endtask

    initial begin
        int done_cnt;
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        drive(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy", {63'd0, busy32}, 64'd0);
        check("rst.done", {63'd0, done32}, 64'd0);
        check("rst.dz",   {63'd0, dz32},   64'd0);
        check("rst.hi",   {32'd0, hi32},   64'd0);
        check("rst.lo",   {32'd0, lo32},   64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        run_div("u100_7",   1'b0, 1'b0, 64'd100,        64'd7,         64'd14,        64'd2,         0);
        run_div("s-7_2",    1'b0, 1'b1, 64'hFFFF_FFF9,  64'd2,         64'hFFFF_FFFD, 64'hFFFF_FFFF, 0);
        run_div("s7_-2",    1'b0, 1'b1, 64'd7,          64'hFFFF_FFFE, 64'hFFFF_FFFD, 64'd1,         0);
        run_div("s-100_-7", 1'b0, 1'b1, 64'hFFFF_FF9C,  64'hFFFF_FFF9, 64'd14,        64'hFFFF_FFFE, 0);
        run_div("smin_-1",  1'b0, 1'b1, 64'h8000_0000,  64'hFFFF_FFFF, 64'h8000_0000, 64'd0,         0);
        run_div("umin_ff",  1'b0, 1'b0, 64'h8000_0000,  64'hFFFF_FFFF, 64'd0,         64'h8000_0000, 0);
        run_div("ubigdvs",  1'b0, 1'b0, 64'hFFFF_FFFF,  64'h8000_0001, 64'd1,         64'h7FFF_FFFE, 0);
        run_div("dz55",     1'b0, 1'b0, 64'd55,         64'd0,         64'd0,         64'd0,         0);
        run_div("after_dz", 1'b0, 1'b0, 64'd1000,       64'd10,        64'd100,       64'd0,         0);
        run_div("restart",  1'b0, 1'b0, 64'd123456,     64'd1000,      64'd123,       64'd456,       5);

        // Reset at edge 10 of a running operation aborts it without a done pulse.
        sel8 = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 64'd5000, 64'd7);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort.busy", {63'd0, busy32}, 64'd0);
        check("abort.done", {63'd0, done32}, 64'd0);
        check("abort.dz",   {63'd0, dz32},   64'd0);
        check("abort.hi",   {32'd0, hi32},   64'd0);
        check("abort.lo",   {32'd0, lo32},   64'd0);
        reset = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done32 || busy32) done_cnt++;
        end
        check("abort.no_done", done_cnt, 0);

        run_div("w8_uff_10",  1'b1, 1'b0, 64'hFF, 64'h10, 64'h0F, 64'h0F, 0);
        run_div("w8_sff_10",  1'b1, 1'b1, 64'hFF, 64'h10, 64'h00, 64'hFF, 0);
        run_div("w8_smin_-1", 1'b1, 1'b1, 64'h80, 64'hFF, 64'h80, 64'h00, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
